// File: rtl/bp_types_pkg.sv
// Shared types for the branch target buffer: sweep FSM states, the entry
// layout at the default geometry, and the saturating direction-counter step.
package bp_types_pkg;

  localparam int BTB_ADDR_W   = 30;
  localparam int BTB_ENTRIES  = 16;
  localparam int BTB_CTR_BITS = 2;
  localparam int BTB_IDX_W    = $clog2(BTB_ENTRIES);
  localparam int BTB_TAG_W    = BTB_ADDR_W - BTB_IDX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } btb_state_t;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_W-1:0]    tag;
    logic [BTB_ADDR_W-1:0]   target;
    logic [BTB_CTR_BITS-1:0] ctr;
  } btb_entry_t;

  // Saturating up/down step for a counter of 'bits' width (1..8). The counter
  // travels zero-extended in an 8-bit carrier so one function serves any width.
  function automatic logic [7:0] ctr_next(input logic [7:0] ctr,
                                          input logic taken,
                                          input int unsigned bits);
    logic [7:0] top;
    top = 8'((9'd1 << bits) - 9'd1);
    if (taken) return (ctr >= top) ? top : ctr + 8'd1;
    else       return (ctr == 8'd0) ? 8'd0 : ctr - 8'd1;
  endfunction

endpackage

// File: rtl/btb_stat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module btb_stat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualified events, holding once every bit is set.
  always_ff @(posedge CLK) begin
    if (RST)                       count <= '0;
    else if (inc && count != '1)   count <= count + W'(1);
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry saturating direction counters, a one-entry
// per cycle invalidate sweep and saturating statistics.
// Handshake: lk_* is a combinational query with no latency; upd_en is a
// one-cycle strobe applied at the next edge unless busy; inv_req is a level
// sampled only in IDLE; busy high means the sweep owns the storage.
module branch_target_buffer
  import bp_types_pkg::*;
#(
  parameter int ADDR_W   = 30,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              lk_en,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              inv_req,
  output logic              busy,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

  btb_state_t       state;
  logic [IDX_W-1:0] idx;

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_go, upd_hit;

  assign lk_idx  = lk_pc[IDX_W-1:0];
  assign lk_tag  = lk_pc[ADDR_W-1:IDX_W];
  assign upd_idx = upd_pc[IDX_W-1:0];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W];

  assign busy    = (state == CLEAR);
  assign upd_go  = upd_en && !busy;
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Predict taken only for a live, matching entry whose counter leans taken.
  assign lk_hit    = !busy && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)
                     && ctr_q[lk_idx][CTR_BITS-1];
  assign lk_target = lk_hit ? tgt_q[lk_idx] : '0;

  // Sweep FSM: reset or an idle inv_req starts a full pass from entry 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inv_req) begin
            state <= CLEAR;
            idx   <= '0;
          end
        end
        CLEAR: begin
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(ENTRIES - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits: cleared by the sweep, set by a taken update that allocates.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (busy)                                valid_q[idx]     <= 1'b0;
      else if (upd_go && upd_taken && !upd_hit) valid_q[upd_idx] <= 1'b1;
    end
  end

  // Entry payload: train on a hit, allocate weakly-taken on a taken miss.
  always_ff @(posedge CLK) begin
    if (!RST && upd_go) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= CTR_BITS'(ctr_next(8'(ctr_q[upd_idx]), upd_taken, CTR_BITS));
        if (upd_taken) tgt_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        tag_q[upd_idx] <= upd_tag;
        tgt_q[upd_idx] <= upd_target;
        ctr_q[upd_idx] <= CTR_WEAK;
      end
    end
  end

  btb_stat_counter #(.W(STAT_W)) u_stat_lookups (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (lk_en && !busy),
    .count (stat_lookups)
  );

  btb_stat_counter #(.W(STAT_W)) u_stat_hits (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (lk_en && lk_hit),
    .count (stat_hits)
  );

  btb_stat_counter #(.W(STAT_W)) u_stat_mispredicts (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (upd_en && upd_mispredict && !busy),
    .count (stat_mispredicts)
  );

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Parametrised direct-mapped branch target buffer with per-entry saturating direction counters. It is the next-generation replacement for the fixed single-bit predictor in the 5-stage pipeline. The IF stage looks it up combinationally with the word-addressed PC. The ID stage writes back resolved branch outcomes. It adds a sequenced invalidate sweep and saturating performance counters, which the previous predictor lacked.

Parameters:
ADDR_W, 30, word-address width (byte PC >> 2)
ENTRIES, 16, number of entries; power of two, >= 2
CTR_BITS, 2, width of the saturating direction counter; >= 1
STAT_W, 32, width of each statistics counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
lk_en  in  1  lookup qualifier (IF stage ihit)
lk_pc  in  ADDR_W  word PC being fetched
lk_hit  out  1  predict taken: entry valid, tag match, counter MSB set, not busy
lk_target  out  ADDR_W  predicted target; 0 when lk_hit=0
upd_en  in  1  resolved-branch update strobe (ID stage)
upd_pc  in  ADDR_W  word PC of the resolved branch
upd_taken  in  1  actual direction
upd_target  in  ADDR_W  actual target (valid when upd_taken)
upd_mispredict  in  1  ID flagged a mispredict; stats only
inv_req  in  1  request a full invalidate sweep
busy  out  1  sweep in progress
stat_lookups  out  STAT_W  qualified lookups
stat_hits  out  STAT_W  lookups with lk_hit=1
stat_mispredicts  out  STAT_W  updates flagged as mispredicts

Behaviour:
- Address split: IDX_W = log2(ENTRIES). Index = pc[IDX_W-1:0]. Tag = pc[ADDR_W-1:IDX_W].
- Each entry holds: valid, tag, target[ADDR_W], ctr[CTR_BITS].
- Lookup is combinational, with no cycle of latency. lk_hit and lk_target depend only on lk_pc, the current storage, and the state. lk_en gates only the statistics.
- Update is registered and visible to lookups from the next cycle.
  - There is no same-cycle bypass: a lookup and an update to the same index in the same cycle returns the old contents.
- Update on hit (valid and tag match):
  - Taken: ctr increments, saturating at 2^CTR_BITS-1, and target <= upd_target.
  - Not taken: ctr decrements, saturating at 0, and target is kept.
- Update on miss:
  - Taken: allocate (overwriting any aliasing entry) with valid=1, new tag, target, ctr = 2^(CTR_BITS-1) (weakly taken).
  - Not taken: no change.
- States: IDLE and CLEAR, plus a sweep index register idx[IDX_W].
  - IDLE -> CLEAR when inv_req=1; idx <= 0.
  - In CLEAR, one entry per cycle: valid[idx] <= 0, then idx++. After clearing entry ENTRIES-1, go to IDLE. A sweep lasts exactly ENTRIES cycles.
  - busy = (state == CLEAR). While busy: lk_hit=0, upd_en is ignored, inv_req is ignored (no restart).
- Reset (RST=1 on an edge):
  - state <= CLEAR, idx <= 0, all stats <= 0. busy=1 and lk_hit=0 in the first cycle after reset.
  - Tag, target and ctr storage are not reset; the sweep clears valid.
  - RST asserted mid-sweep restarts the sweep from idx 0.
- Statistics all saturate at all-ones with no wrap.
  - stat_lookups += lk_en & !busy.
  - stat_hits += lk_en & lk_hit.
  - stat_mispredicts += upd_en & upd_mispredict & !busy.
- An inv_req arriving in the same cycle as upd_en in IDLE: the update is applied, then the sweep starts next cycle.

Decomposition:
- Shared package bp_types_pkg holds:
  - btb_state_t enum {IDLE, CLEAR}
  - btb_entry_t packed struct {valid, tag, target, ctr}, parameterised via localparams
  - function ctr_next(ctr, taken) for saturating up/down counting
- One natural sub-module, btb_stat_counter: an STAT_W saturating event counter with sync reset, instantiated three times.

Test Plan:
1. Reset, then idle: busy=1 for exactly 16 cycles after RST deasserts, then busy=0. Any lk_pc gives lk_hit=0 and lk_target=0 throughout.
2. Allocate and lookup:
   - upd pc=0x040, taken, target=0x100. Next cycle, lk_pc=0x040 gives lk_hit=1, lk_target=0x100 (ctr=2).
   - Same cycle as the update, lk_pc=0x040 gives lk_hit=0 (no bypass).
3. Counter training:
   - Two not-taken updates to pc=0x040: ctr 2->1->0; the lookup misses (lk_hit=0) while the entry stays valid.
   - Then four taken updates: ctr 1,2,3,3 (saturates). lk_hit=1 from the second taken update onward.
4. Aliasing: after test 2, upd pc=0x050 (same index 0, different tag), taken, target=0x200. Then lk_pc=0x040 misses and lk_pc=0x050 hits with target 0x200.
5. Invalidate sweep:
   - With entries populated, pulse inv_req: busy=1 for 16 cycles and all lookups miss.
   - An upd_en taken to pc=0x060 during the sweep is ignored: after the sweep, lk_pc=0x060 misses.
   - RST asserted at sweep cycle 8 restarts the sweep, giving 16 more busy cycles.
6. Statistics: 5 qualified lookups, 3 of them hitting, plus 2 updates with upd_mispredict=1 give stat_lookups=5, stat_hits=3, stat_mispredicts=2. A counter preloaded to all-ones stays at all-ones after a further event.
